// File: rtl/gcd_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : gcd_operand_sequencer_if
// Brief    : Operand, GCD-core and result handshake bundle for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface gcd_operand_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             gcd_clear;
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_data;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;

    // master = the sequencer, slave = upstream/core/downstream environment
    modport master (
        input  in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
        output in_ready, gcd_clear, gcd_start, gcd_data, out_valid, out_result, out_err
    );

    modport slave (
        output in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
        input  in_ready, gcd_clear, gcd_start, gcd_data, out_valid, out_result, out_err
    );
endinterface
`default_nettype wire

// File: rtl/gcd_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gcd_operand_sequencer
// Brief    : Feeds an operand pair serially to a GCD core, waits for the core
//            with a timeout, and returns the result over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_operand_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input wire clk,
    input wire rst_n,
    gcd_operand_sequencer_if.master bus
);

    localparam logic [9:0] c_timeout = 10'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_WAIT   = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic [9:0]       r_cnt;

    logic [WIDTH-1:0] w_op_a_nxt;
    logic [WIDTH-1:0] w_op_b_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_err_nxt;
    logic [9:0]       w_cnt_nxt;
    logic [9:0]       w_cnt_inc;

    logic             w_in_ready;
    logic             w_gcd_clear;
    logic             w_gcd_start;
    logic [WIDTH-1:0] w_gcd_data;
    logic             w_out_valid;

    assign w_cnt_inc = r_cnt + 10'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_cnt    <= 10'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_op_a   <= w_op_a_nxt;
            r_op_b   <= w_op_b_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_op_a_nxt   = r_op_a;
        w_op_b_nxt   = r_op_b;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        w_cnt_nxt    = r_cnt;
        w_in_ready   = 1'b0;
        w_gcd_clear  = 1'b0;
        w_gcd_start  = 1'b0;
        w_gcd_data   = '0;
        w_out_valid  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_op_a_nxt = bus.in_a;
                    w_op_b_nxt = bus.in_b;
                    // A zero operand makes the answer trivial, so the core is skipped
                    if (bus.in_a == '0 || bus.in_b == '0) begin
                        w_result_nxt = (bus.in_a == '0) ? bus.in_b : bus.in_a;
                        w_err_nxt    = 1'b0;
                        w_state_nxt  = S_OUT;
                    end else begin
                        w_state_nxt  = S_CLR;
                    end
                end
            end
            S_CLR: begin
                w_gcd_clear = 1'b1;
                w_state_nxt = S_LOAD_A;
            end
            S_LOAD_A: begin
                w_gcd_start = 1'b1;
                w_gcd_data  = r_op_a;
                w_state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                w_gcd_start = 1'b1;
                w_gcd_data  = r_op_b;
                w_cnt_nxt   = 10'd0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // done is checked first so it wins over a coincident timeout
                if (bus.gcd_done) begin
                    w_result_nxt = bus.gcd_result;
                    w_err_nxt    = 1'b0;
                    w_state_nxt  = S_OUT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_timeout) begin
                        w_result_nxt = '0;
                        w_err_nxt    = 1'b1;
                        w_state_nxt  = S_OUT;
                    end
                end
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes are forced low while reset is held, whatever state is registered
    assign bus.in_ready   = rst_n & w_in_ready;
    assign bus.gcd_clear  = rst_n & w_gcd_clear;
    assign bus.gcd_start  = rst_n & w_gcd_start;
    assign bus.gcd_data   = rst_n ? w_gcd_data : '0;
    assign bus.out_valid  = rst_n & w_out_valid;
    assign bus.out_result = r_result;
    assign bus.out_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gcd_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_operand_sequencer
// Brief    : Directed and randomized bench with a GCD core model and a
//            timeline reference model of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_operand_sequencer;

    localparam int c_width   = 16;
    localparam int c_timeout = 40;
    localparam int c_never   = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd_operand_sequencer_if #(.WIDTH(c_width)) bus ();

    gcd_operand_sequencer #(
        .WIDTH   (c_width),
        .TIMEOUT (c_timeout)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        x = a;
        y = b;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // out_ready source: directed value or a random bit
    logic rnd_ready = 1'b0;
    logic dir_ready = 1'b0;
    logic rnd_bit   = 1'b0;
    assign bus.out_ready = rnd_ready ? rnd_bit : dir_ready;
    always @(posedge clk) begin
        #2 rnd_bit = 1'($urandom_range(0, 1));
    end

    // GCD core model: takes two serial operands, answers after cur_dly cycles
    int          drv_dly = 0;
    int          cur_dly = 0;
    logic        c_done  = 1'b0;
    logic [15:0] c_res   = 16'd0;
    logic [15:0] c_a     = 16'd0;
    logic [15:0] c_b     = 16'd0;
    int          c_n     = 0;
    int          c_cnt   = 0;
    logic        c_arm   = 1'b0;
    assign bus.gcd_done   = c_done;
    assign bus.gcd_result = c_res;

    always @(posedge clk) begin
        if (bus.gcd_clear) begin
            c_n    <= 0;
            c_done <= 1'b0;
            c_arm  <= 1'b0;
        end else if (bus.gcd_start) begin
            if (c_n == 0) begin
                c_a <= bus.gcd_data;
                c_n <= 1;
            end else if (c_n == 1) begin
                c_b <= bus.gcd_data;
                c_n <= 2;
                if (cur_dly == 0) begin
                    c_done <= 1'b1;
                    c_res  <= gcd_ref(c_a, bus.gcd_data);
                end else begin
                    c_cnt <= cur_dly;
                    c_arm <= 1'b1;
                end
            end
        end else if (c_arm && !c_done) begin
            if (c_cnt == 1) begin
                c_done <= 1'b1;
                c_res  <= gcd_ref(c_a, c_b);
                c_arm  <= 1'b0;
            end
            c_cnt <= c_cnt - 1;
        end
    end

    // Reference model: per transaction, k counts cycles since acceptance
    int          cyc     = 0;
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    logic        m_busy  = 1'b0;
    logic        m_byp   = 1'b0;
    logic        m_err   = 1'b0;
    int          m_k     = 0;
    int          m_out_k = 0;
    logic [15:0] m_a     = 16'd0;
    logic [15:0] m_b     = 16'd0;
    logic [15:0] m_res   = 16'd0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy  = 1'b1;
                m_k     = 1;
                m_a     = bus.in_a;
                m_b     = bus.in_b;
                m_byp   = (m_a == 16'd0) || (m_b == 16'd0);
                acc_cnt = acc_cnt + 1;
                acc_cyc = cyc;
                cur_dly = drv_dly;
                if (m_byp) begin
                    m_out_k = 1;
                    m_res   = (m_a == 16'd0) ? m_b : m_a;
                    m_err   = 1'b0;
                end else if (drv_dly < c_timeout) begin
                    m_out_k = 5 + drv_dly;
                    m_res   = gcd_ref(m_a, m_b);
                    m_err   = 1'b0;
                end else begin
                    m_out_k = 4 + c_timeout;
                    m_res   = 16'd0;
                    m_err   = 1'b1;
                end
            end
        end else begin
            if (m_k >= m_out_k && bus.out_ready) m_busy = 1'b0;
            else m_k = m_k + 1;
        end
        cyc = cyc + 1;
    end

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          lat;
    } res_t;
    res_t res_q[$];
    int   rise_lat   = 0;
    logic prev_valid = 1'b0;

    // Compare process: every cycle, DUT outputs against the model
    always @(negedge clk) begin
        logic        e_rdy;
        logic        e_clr;
        logic        e_st;
        logic        e_val;
        logic [15:0] e_dat;
        e_rdy = 1'b0;
        e_clr = 1'b0;
        e_st  = 1'b0;
        e_val = 1'b0;
        e_dat = 16'd0;
        if (rst_n) begin
            if (!m_busy) begin
                e_rdy = 1'b1;
            end else begin
                e_clr = !m_byp && (m_k == 1);
                e_st  = !m_byp && (m_k == 2 || m_k == 3);
                if (!m_byp && m_k == 2) e_dat = m_a;
                else if (!m_byp && m_k == 3) e_dat = m_b;
                e_val = (m_k >= m_out_k);
            end
        end
        chk("in_ready",  32'(bus.in_ready),  32'(e_rdy));
        chk("gcd_clear", 32'(bus.gcd_clear), 32'(e_clr));
        chk("gcd_start", 32'(bus.gcd_start), 32'(e_st));
        chk("gcd_data",  32'(bus.gcd_data),  32'(e_dat));
        chk("out_valid", 32'(bus.out_valid), 32'(e_val));
        if (e_val) begin
            chk("out_result", 32'(bus.out_result), 32'(m_res));
            chk("out_err",    32'(bus.out_err),    32'(m_err));
        end
        if (bus.out_valid && !prev_valid) rise_lat = cyc - acc_cyc;
        prev_valid = bus.out_valid;
        if (bus.out_valid && bus.out_ready && rst_n)
            res_q.push_back('{res: bus.out_result, err: bus.out_err, lat: rise_lat});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input int dly);
        int c0;
        int n;
        c0 = acc_cnt;
        n  = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        drv_dly      = dly;
        while (acc_cnt == c0 && n < 500) begin
            step(1);
            n++;
        end
        if (acc_cnt == c0) chk("accept_timeout", 32'(n), 32'd0);
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
    endtask

    task automatic wait_result(output logic [15:0] r, output logic e, output int lat);
        res_t x;
        int   n;
        n = 0;
        while (res_q.size() == 0 && n < 300) begin
            step(1);
            n++;
        end
        if (res_q.size() == 0) begin
            chk("result_timeout", 32'(n), 32'd0);
            r   = 16'd0;
            e   = 1'b0;
            lat = -1;
        end else begin
            x   = res_q.pop_front();
            r   = x.res;
            e   = x.err;
            lat = x.lat;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        logic        e;
        int          lat;
        int          a0;
        int          n;

        bus.in_valid = 1'b0;
        bus.in_a     = 16'd0;
        bus.in_b     = 16'd0;
        rst_n        = 1'b0;
        step(3);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready",   32'(bus.in_ready),   32'd1);
        chk("reset_out_result", 32'(bus.out_result), 32'd0);
        chk("reset_out_err",    32'(bus.out_err),    32'd0);

        dir_ready = 1'b1;
        send(16'd143, 16'd78, 3);
        wait_result(r, e, lat);
        chk("seq_core_a",  32'(c_a), 32'd143);
        chk("seq_core_b",  32'(c_b), 32'd78);
        chk("seq_result",  32'(r),   32'd13);
        chk("seq_err",     32'(e),   32'd0);
        chk("seq_latency", 32'(lat), 32'd8);

        send(16'd0, 16'd36, 0);
        wait_result(r, e, lat);
        chk("byp_b_result",  32'(r),   32'd36);
        chk("byp_b_err",     32'(e),   32'd0);
        chk("byp_b_latency", 32'(lat), 32'd1);
        send(16'd0, 16'd0, 0);
        wait_result(r, e, lat);
        chk("byp_zero_result", 32'(r), 32'd0);
        send(16'd25, 16'd0, 0);
        wait_result(r, e, lat);
        chk("byp_a_result", 32'(r), 32'd25);

        send(16'd7, 16'd21, c_never);
        wait_result(r, e, lat);
        chk("tmo_result",  32'(r),   32'd0);
        chk("tmo_err",     32'(e),   32'd1);
        chk("tmo_latency", 32'(lat), 32'd44);

        send(16'd35, 16'd14, c_timeout - 1);
        wait_result(r, e, lat);
        chk("donewin_result",  32'(r),   32'd7);
        chk("donewin_err",     32'(e),   32'd0);
        chk("donewin_latency", 32'(lat), 32'd44);

        dir_ready = 1'b0;
        send(16'd12, 16'd18, 0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            step(1);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid",    32'(bus.out_valid),  32'd1);
            chk("hold_result",   32'(bus.out_result), 32'd6);
            chk("hold_err",      32'(bus.out_err),    32'd0);
            chk("hold_in_ready", 32'(bus.in_ready),   32'd0);
            step(1);
        end
        dir_ready = 1'b1;
        step(1);
        chk("idle_in_ready",  32'(bus.in_ready),  32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        wait_result(r, e, lat);
        chk("hold_final_result", 32'(r), 32'd6);

        send(16'd48, 16'd18, c_never);
        step(6);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(60);
        chk("abort_no_result", 32'(res_q.size()), 32'd0);
        send(16'd48, 16'd18, 2);
        wait_result(r, e, lat);
        chk("restart_result",  32'(r),   32'd6);
        chk("restart_latency", 32'(lat), 32'd7);

        send(16'd100, 16'd75, 1);
        a0 = acc_cyc;
        send(16'd81, 16'd27, 0);
        chk("b2b_accept_gap", 32'(acc_cyc - a0), 32'd7);
        wait_result(r, e, lat);
        chk("b2b_first",  32'(r), 32'd25);
        wait_result(r, e, lat);
        chk("b2b_second", 32'(r), 32'd27);

        rnd_ready = 1'b1;
        for (int t = 0; t < 150; t++) begin
            logic [15:0] a;
            logic [15:0] b;
            int          d;
            int          sel;
            sel = int'($urandom_range(0, 7));
            a   = 16'($urandom_range(1, 255));
            b   = 16'($urandom_range(1, 255));
            if (sel == 0) a = 16'd0;
            else if (sel == 1) b = 16'd0;
            else if (sel == 2) a = 16'($urandom);
            else if (sel == 3) a = 16'(b * 16'($urandom_range(1, 9)));
            if ($urandom_range(0, 29) == 0) d = c_never;
            else if ($urandom_range(0, 3) == 0) d = int'($urandom_range(c_timeout - 3, c_timeout + 3));
            else d = int'($urandom_range(0, 8));
            send(a, b, d);
            if ($urandom_range(0, 39) == 0) begin
                step(int'($urandom_range(0, 10)));
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            step(int'($urandom_range(0, 3)));
        end
        rnd_ready = 1'b0;
        dir_ready = 1'b1;
        step(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
